// File: rtl/soc_pkg.sv
// soc_pkg: shared LSU size encodings and AXI response codes
package soc_pkg;
  localparam logic [1:0] BYTE = 2'd0;
  localparam logic [1:0] HALF = 2'd1;
  localparam logic [1:0] WORD = 2'd2;
  localparam logic [1:0] EXTA = 2'd3;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: one-outstanding LSU req/resp port to AXI4-Lite master (req_*/resp_*/busy on LSU side, m_aw/w/b/ar/r channels on bus side), all outputs registered
module lsu_axi_bridge import soc_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wmask,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awsize,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arsize,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  state_t state, state_n;
  logic aw_done, w_done, aw_done_n, w_done_n, err_n;
  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    err_n     = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        state_n   = req_wen ? WR_REQ : RD_ADDR;
        aw_done_n = 1'b0;
        w_done_n  = 1'b0;
      end
      RD_ADDR: state_n = m_arready ? RD_DATA : RD_ADDR;
      RD_DATA: begin
        state_n = m_rvalid ? DONE : RD_DATA;
        err_n   = m_rresp != OKAY;
      end
      WR_REQ: begin
        aw_done_n = aw_done | (m_awvalid & m_awready);
        w_done_n  = w_done | (m_wvalid & m_wready);
        state_n   = (aw_done_n && w_done_n) ? WR_RESP : WR_REQ;
      end
      WR_RESP: begin
        state_n = m_bvalid ? DONE : WR_RESP;
        err_n   = m_bresp != OKAY;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      m_awaddr   <= '0;
      m_araddr   <= '0;
      m_awsize   <= '0;
      m_arsize   <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      busy       <= 1'b0;
    end else begin
      state   <= state_n;
      aw_done <= aw_done_n;
      w_done  <= w_done_n;
      if (state == IDLE && req_valid) begin
        m_awaddr <= req_addr;
        m_araddr <= req_addr;
        m_awsize <= {1'b0, req_size};
        m_arsize <= {1'b0, req_size};
        m_wdata  <= req_wdata;
        m_wstrb  <= req_wmask;
      end
      if (state == RD_DATA && m_rvalid) resp_rdata <= m_rdata;
      m_arvalid  <= state_n == RD_ADDR;
      m_rready   <= state_n == RD_DATA;
      m_awvalid  <= state_n == WR_REQ && !aw_done_n;
      m_wvalid   <= state_n == WR_REQ && !w_done_n;
      m_bready   <= state_n == WR_RESP;
      resp_valid <= state_n == DONE;
      resp_err   <= state_n == DONE && err_n;
      busy       <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_lsu_axi_bridge.sv
// tb_lsu_axi_bridge: scenario tasks with a response scoreboard for lsu_axi_bridge
module tb_lsu_axi_bridge;
  import soc_pkg::*;
  logic clock = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_wen = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic [3:0] req_wmask = '0;
  logic resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic [31:0] m_awaddr, m_araddr, m_wdata;
  logic [2:0] m_awsize, m_arsize;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [3:0] m_wstrb;
  logic m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0] m_bresp = '0, m_rresp = '0;
  logic [31:0] m_rdata = '0;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];
  logic [31:0] last_rdata = '0;
  int passed = 0, total = 0;
  lsu_axi_bridge #(.ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_araddr(m_araddr),
    .m_arsize(m_arsize), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );
  always #5 clock = ~clock;
  always @(posedge clock)
    if (!reset && req_valid && busy) $error("LSU protocol violation: req_valid while busy");
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [199:0] all_outs();
    return {resp_valid, resp_rdata, resp_err, busy, m_awaddr, m_awsize, m_awvalid, m_wdata, m_wstrb,
            m_wvalid, m_bready, m_araddr, m_arsize, m_arvalid, m_rready};
  endfunction
  task automatic check_resp(input string name);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err)
      $display("FAIL %s resp valid/rdata/err got %0b/%h/%0b exp 1/%h/%0b", name, resp_valid, resp_rdata, resp_err, e.rdata, e.err);
    else passed++;
    step();
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL %s resp not single-cycle valid=%0b busy=%0b", name, resp_valid, busy);
    else passed++;
  endtask
  task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] rdata,
                         input logic [1:0] rresp, input int ar_stall, output int lat);
    exp_t e;
    e.rdata = rdata;
    e.err = rresp != OKAY;
    sb.push_back(e);
    last_rdata = rdata;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_size = size;
    step();
    req_valid = 1'b0;
    lat = 1;
    total++;
    if (m_arvalid !== 1'b1 || m_araddr !== addr || m_arsize !== {1'b0, size} || busy !== 1'b1)
      $display("FAIL rd_ar got valid=%0b addr=%h size=%0d busy=%0b exp 1/%h/%0d/1", m_arvalid, m_araddr, m_arsize, busy, addr, {1'b0, size});
    else passed++;
    for (int i = 0; i < ar_stall; i++) begin
      step();
      lat++;
      total++;
      if (m_arvalid !== 1'b1 || m_araddr !== addr) $display("FAIL rd_ar_stall got valid=%0b addr=%h exp 1/%h", m_arvalid, m_araddr, addr);
      else passed++;
    end
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    lat++;
    total++;
    if (m_arvalid !== 1'b0 || m_rready !== 1'b1) $display("FAIL rd_r_phase got arvalid=%0b rready=%0b exp 0/1", m_arvalid, m_rready);
    else passed++;
    m_rvalid = 1'b1; m_rdata = rdata; m_rresp = rresp;
    step();
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = OKAY;
    lat++;
    check_resp("rd_resp");
  endtask
  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata, input logic [3:0] wmask,
                          input int aw_stall, input int w_stall, input logic [1:0] bresp, output int lat);
    exp_t e;
    int last;
    e.rdata = last_rdata;
    e.err = bresp != OKAY;
    sb.push_back(e);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_size = size; req_wdata = wdata; req_wmask = wmask;
    step();
    req_valid = 1'b0; req_wen = 1'b0;
    lat = 1;
    total++;
    if (m_awaddr !== addr || m_awsize !== {1'b0, size} || m_wdata !== wdata || m_wstrb !== wmask)
      $display("FAIL wr_payload got %h/%0d/%h/%h exp %h/%0d/%h/%h", m_awaddr, m_awsize, m_wdata, m_wstrb, addr, {1'b0, size}, wdata, wmask);
    else passed++;
    last = aw_stall > w_stall ? aw_stall : w_stall;
    for (int c = 0; c <= last; c++) begin
      total++;
      if (m_awvalid !== (c <= aw_stall) || m_wvalid !== (c <= w_stall))
        $display("FAIL wr_valids cyc %0d got aw=%0b w=%0b exp %0b/%0b", c, m_awvalid, m_wvalid, c <= aw_stall, c <= w_stall);
      else passed++;
      m_awready = c == aw_stall;
      m_wready = c == w_stall;
      step();
      lat++;
    end
    m_awready = 1'b0; m_wready = 1'b0;
    total++;
    if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || m_bready !== 1'b1)
      $display("FAIL wr_b_phase got aw=%0b w=%0b bready=%0b exp 0/0/1", m_awvalid, m_wvalid, m_bready);
    else passed++;
    m_bvalid = 1'b1; m_bresp = bresp;
    step();
    m_bvalid = 1'b0; m_bresp = OKAY;
    lat++;
    check_resp("wr_resp");
  endtask
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if (all_outs() !== '0) $display("FAIL reset_outputs got %h exp 0", all_outs());
    else passed++;
    reset = 1'b0;
    step();
    total++;
    if (all_outs() !== '0) $display("FAIL idle_outputs got %h exp 0", all_outs());
    else passed++;
  endtask
  task automatic test_read_basic();
    int lat;
    do_read(32'h8000_0004, WORD, 32'hCAFE_BABE, OKAY, 0, lat);
    total++;
    if (lat !== 3) $display("FAIL read_latency got %0d exp 3", lat);
    else passed++;
  endtask
  task automatic test_write_staggered();
    int lat;
    do_write(32'h8000_0002, HALF, 32'h1234_0000, 4'b1100, 2, 0, OKAY, lat);
    total++;
    if (lat !== 5) $display("FAIL write_stagger_latency got %0d exp 5", lat);
    else passed++;
    do_write(32'h0000_0010, WORD, 32'hA5A5_5A5A, 4'hF, 0, 0, OKAY, lat);
    total++;
    if (lat !== 3) $display("FAIL write_latency got %0d exp 3", lat);
    else passed++;
  endtask
  task automatic test_back_to_back();
    int lat1, lat2;
    do_read(32'h0000_1001, WORD, 32'h1122_3344, OKAY, 0, lat1);
    do_read(32'h0000_1004, WORD, 32'h5566_7788, OKAY, 0, lat2);
    total++;
    if (lat1 !== 3 || lat2 !== 3) $display("FAIL b2b_latency got %0d/%0d exp 3/3", lat1, lat2);
    else passed++;
  endtask
  task automatic test_read_err();
    int lat;
    do_read(32'h4000_0000, WORD, 32'hDEAD_BEEF, SLVERR, 0, lat);
    do_write(32'h4000_0008, BYTE, 32'h0000_00FF, 4'b0001, 1, 3, OKAY, lat);
    total++;
    if (resp_rdata !== 32'hDEAD_BEEF) $display("FAIL rdata_hold got %h exp deadbeef", resp_rdata);
    else passed++;
    do_write(32'h4000_000C, WORD, 32'h0, 4'hF, 0, 0, DECERR, lat);
  endtask
  task automatic test_ar_stall();
    int lat;
    do_read(32'h2000_0040, WORD, 32'h0BAD_F00D, OKAY, 5, lat);
    total++;
    if (lat !== 8) $display("FAIL ar_stall_latency got %0d exp 8", lat);
    else passed++;
  endtask
  task automatic test_reset_in_wr_resp();
    int lat;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h3000_0000; req_size = WORD; req_wdata = 32'h1; req_wmask = 4'hF;
    step();
    req_valid = 1'b0; req_wen = 1'b0;
    m_awready = 1'b1; m_wready = 1'b1;
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    total++;
    if (m_bready !== 1'b1) $display("FAIL rst_wr_resp_reached got bready=%0b exp 1", m_bready);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_rdata = '0;
    total++;
    if (all_outs() !== '0) $display("FAIL rst_mid_outputs got %h exp 0", all_outs());
    else passed++;
    do_read(32'h3000_0100, WORD, 32'h7777_8888, OKAY, 0, lat);
    total++;
    if (lat !== 3) $display("FAIL rst_recover_latency got %0d exp 3", lat);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_read_basic();
    test_write_staggered();
    test_back_to_back();
    test_read_err();
    test_ar_stall();
    test_reset_in_wr_resp();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
